// File: rtl/pipe_add.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES slices, one slice's
// carry chain resolved per stage, valid/ready handshake with a global stall.
module pipe_add #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int SW = WIDTH / STAGES;
   localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int LS = STAGES - 1;

   if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_add: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   logic             en;
   logic [WIDTH-1:0] w_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic             c_in [STAGES];
   logic             v_in [STAGES];
   logic [WIDTH-1:0] w_nx [STAGES];
   logic             c_nx [STAGES];
   logic [SW:0]      slice_sum;
   logic             msb_cin;

   // w_q holds finished low slices with the still-unprocessed high slices of a
   logic [WIDTH-1:0] w_q [NR];
   logic [WIDTH-1:0] w_d [NR];
   logic [WIDTH-1:0] b_q [NR];
   logic [WIDTH-1:0] b_d [NR];
   logic             c_q [NR];
   logic             c_d [NR];
   logic             v_q [NR];
   logic             v_d [NR];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   assign en = !out_valid_q | out_ready;

   always_comb begin
      slice_sum = '0;
      w_in[0]   = a;
      b_in[0]   = sub ? ~b : b;
      c_in[0]   = cin;
      v_in[0]   = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_in[k] = w_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         v_in[k] = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice_sum = {1'b0, w_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                   + {{SW{1'b0}}, c_in[k]};
         w_nx[k] = w_in[k];
         w_nx[k][k*SW +: SW] = slice_sum[SW-1:0];
         c_nx[k] = slice_sum[SW];
      end
      // carry into the MSB recovered from its sum bit and operand bits
      msb_cin = w_nx[LS][WIDTH-1] ^ w_in[LS][WIDTH-1] ^ b_in[LS][WIDTH-1];
   end

   if (STAGES > 1) begin : g_msb_only
      logic unused_b_lo;
      assign unused_b_lo = ^b_in[LS][WIDTH-SW-1:0];
   end

   always_comb begin
      for (int k = 0; k < NR; k++) begin
         w_d[k] = w_q[k];
         b_d[k] = b_q[k];
         c_d[k] = c_q[k];
         v_d[k] = v_q[k];
      end
      out_valid_d = out_valid_q;
      out_d       = out_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      if (en) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            w_d[k] = w_nx[k];
            b_d[k] = b_in[k];
            c_d[k] = c_nx[k];
            v_d[k] = v_in[k];
         end
         out_valid_d = v_in[LS];
         // bubbles leave the last result and flags untouched
         if (v_in[LS]) begin
            out_d  = w_nx[LS];
            cout_d = c_nx[LS];
            ovf_d  = c_nx[LS] ^ msb_cin;
            zero_d = ~|w_nx[LS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NR; k++) begin
            w_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         out_valid_q <= 1'b0;
         out_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         for (int k = 0; k < NR; k++) begin
            w_q[k] <= w_d[k];
            b_q[k] <= b_d[k];
            c_q[k] <= c_d[k];
            v_q[k] <= v_d[k];
         end
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: three configurations (16/4, 32/8, 8/1) checked against an
// arithmetic reference model with directed, back-to-back, stall and reset scenarios.
`timescale 1ns/1ps
module tb_pipe_add;
   localparam int ND = 3;
   localparam int DW [ND] = '{16, 32, 8};
   localparam int DL [ND] = '{4, 8, 1};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [ND-1:0] in_valid_s, in_ready_s, out_valid_s, out_ready_s;
   logic [ND-1:0] cin_s, sub_s, cout_s, ovf_s, zero_s;
   logic [15:0]   a16, b16, out16;
   logic [31:0]   a32, b32, out32;
   logic [7:0]    a8, b8, out8;
   int            n_checks = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   pipe_add #(.WIDTH(16), .STAGES(4)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .a(a16), .b(b16), .cin(cin_s[0]), .sub(sub_s[0]), .out_valid(out_valid_s[0]),
      .out_ready(out_ready_s[0]), .out(out16), .cout(cout_s[0]), .ovf(ovf_s[0]), .zero(zero_s[0]));
   pipe_add #(.WIDTH(32), .STAGES(8)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .a(a32), .b(b32), .cin(cin_s[1]), .sub(sub_s[1]), .out_valid(out_valid_s[1]),
      .out_ready(out_ready_s[1]), .out(out32), .cout(cout_s[1]), .ovf(ovf_s[1]), .zero(zero_s[1]));
   pipe_add #(.WIDTH(8), .STAGES(1)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .a(a8), .b(b8), .cin(cin_s[2]), .sub(sub_s[2]), .out_valid(out_valid_s[2]),
      .out_ready(out_ready_s[2]), .out(out8), .cout(cout_s[2]), .ovf(ovf_s[2]), .zero(zero_s[2]));

   function automatic logic [31:0] mask_of(input int w);
      return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] out_of(input int d);
      case (d)
         0:       return {16'h0, out16};
         1:       return out32;
         default: return {24'h0, out8};
      endcase
   endfunction

   // Reference: unsigned sum for result/carry, signed-range test for overflow
   task automatic model_add(input int w, input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic su, output logic [31:0] r,
                            output logic co, output logic ov, output logic z);
      longint m, ua, ub, s, sa, sb, ss;
      m  = longint'(1) << w;
      ua = longint'(av) & (m - 1);
      ub = (su ? ~longint'(bv) : longint'(bv)) & (m - 1);
      s  = ua + ub + longint'(ci);
      r  = 32'(s % m);
      co = (s >= m);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      ss = sa + sb + longint'(ci);
      ov = (ss >= m / 2) || (ss < -(m / 2));
      z  = (r == 32'd0);
   endtask

   task automatic drive(input int d, input logic v, input logic [31:0] av,
                        input logic [31:0] bv, input logic ci, input logic su);
      in_valid_s[d] = v;
      cin_s[d]      = ci;
      sub_s[d]      = su;
      case (d)
         0:       begin a16 = av[15:0]; b16 = bv[15:0]; end
         1:       begin a32 = av;       b32 = bv;       end
         default: begin a8  = av[7:0];  b8  = bv[7:0];  end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      for (int d = 0; d < ND; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      out_ready_s = '1;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      out_ready_s = '1;
      step();
      step();
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         n_checks++;
         if ({out_valid_s[d], out_of(d), cout_s[d], ovf_s[d], zero_s[d], in_ready_s[d]}
             !== {1'b0, 32'h0, 3'b000, 1'b1})
            $display("FAIL reset d=%0d got v=%b out=%h c=%b o=%b z=%b rdy=%b exp v=0 out=0 flags=0 rdy=1",
                     d, out_valid_s[d], out_of(d), cout_s[d], ovf_s[d], zero_s[d], in_ready_s[d]);
         else n_pass++;
      end
   endtask

   task automatic test_directed();
      logic [31:0] m, av, bv, er;
      logic        ci, su, ec, eo, ez;
      for (int d = 0; d < ND; d++) begin
         m = mask_of(DW[d]);
         for (int i = 0; i < 6; i++) begin
            case (i)
               0:       begin av = (32'd1 << (DW[d] / 2)) - 32'd1; bv = 32'd1; ci = 1'b0; su = 1'b0; end
               1:       begin av = m;                bv = 32'd1; ci = 1'b0; su = 1'b0; end
               2:       begin av = m >> 1;           bv = 32'd1; ci = 1'b0; su = 1'b0; end
               3:       begin av = 32'd5;            bv = 32'd7; ci = 1'b1; su = 1'b1; end
               4:       begin av = (m >> 1) + 32'd1; bv = 32'd1; ci = 1'b1; su = 1'b1; end
               default: begin av = 32'd5;            bv = 32'd3; ci = 1'b0; su = 1'b1; end
            endcase
            model_add(DW[d], av, bv, ci, su, er, ec, eo, ez);
            out_ready_s[d] = 1'b1;
            drive(d, 1'b1, av, bv, ci, su);
            step();
            drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            for (int k = 1; k <= DL[d]; k++) begin
               n_checks++;
               if (k < DL[d]) begin
                  if (out_valid_s[d] !== 1'b0)
                     $display("FAIL early_valid d=%0d i=%0d cycle=%0d got=%b exp=0", d, i, k, out_valid_s[d]);
                  else n_pass++;
                  step();
               end else begin
                  if ({out_valid_s[d], out_of(d), cout_s[d], ovf_s[d], zero_s[d]} !== {1'b1, er, ec, eo, ez})
                     $display("FAIL directed d=%0d i=%0d got v=%b out=%h c=%b o=%b z=%b exp v=1 out=%h c=%b o=%b z=%b",
                              d, i, out_valid_s[d], out_of(d), cout_s[d], ovf_s[d], zero_s[d], er, ec, eo, ez);
                  else n_pass++;
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back(input int d);
      localparam int N = 10;
      logic [34:0] exp_v [N];
      logic [31:0] av, bv, er;
      logic        ci, su, ec, eo, ez;
      int          idx;
      flush();
      for (int c = 0; c < N + DL[d] - 1; c++) begin
         if (c < N) begin
            av = $urandom & mask_of(DW[d]);
            bv = $urandom & mask_of(DW[d]);
            ci = 1'($urandom);
            su = 1'($urandom);
            model_add(DW[d], av, bv, ci, su, er, ec, eo, ez);
            exp_v[c] = {eo, ec, ez, er};
            drive(d, 1'b1, av, bv, ci, su);
         end else drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         step();
         idx = c + 1 - DL[d];
         n_checks++;
         if (idx < 0) begin
            if (out_valid_s[d] !== 1'b0)
               $display("FAIL b2b_latency d=%0d cycle=%0d got v=%b exp v=0", d, c + 1, out_valid_s[d]);
            else n_pass++;
         end else begin
            if ({out_valid_s[d], ovf_s[d], cout_s[d], zero_s[d], out_of(d)} !== {1'b1, exp_v[idx]})
               $display("FAIL b2b d=%0d beat=%0d got v=%b {o,c,z,out}=%h exp v=1 {o,c,z,out}=%h",
                        d, idx, out_valid_s[d], {ovf_s[d], cout_s[d], zero_s[d], out_of(d)}, exp_v[idx]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure(input int d);
      logic [34:0] q [$];
      logic [34:0] got_v, exp_v, hold_v;
      logic [31:0] av, bv, er;
      logic        ci, su, ec, eo, ez, stalled;
      int          sent, got, cyc;
      flush();
      stalled = 1'b0;
      hold_v  = '0;
      sent = 0; got = 0; cyc = 0;
      while (got < 8 && cyc < 400) begin
         av = $urandom & mask_of(DW[d]);
         bv = $urandom & mask_of(DW[d]);
         ci = 1'($urandom);
         su = 1'($urandom);
         drive(d, sent < 8, av, bv, ci, su);
         out_ready_s[d] = 1'($urandom);
         #1;
         got_v = {ovf_s[d], cout_s[d], zero_s[d], out_of(d)};
         if (stalled) begin
            n_checks++;
            if ({out_valid_s[d], got_v} !== {1'b1, hold_v})
               $display("FAIL stall_hold d=%0d got v=%b val=%h exp v=1 val=%h", d, out_valid_s[d], got_v, hold_v);
            else n_pass++;
         end
         if (out_valid_s[d] && !out_ready_s[d]) begin
            n_checks++;
            if (in_ready_s[d] !== 1'b0)
               $display("FAIL stall_in_ready d=%0d got=%b exp=0", d, in_ready_s[d]);
            else n_pass++;
         end
         if (out_valid_s[d] && out_ready_s[d]) begin
            n_checks++;
            if (q.size() == 0)
               $display("FAIL bp_extra d=%0d got unexpected result %h exp none", d, got_v);
            else begin
               exp_v = q.pop_front();
               if (got_v !== exp_v)
                  $display("FAIL bp_order d=%0d beat=%0d got=%h exp=%h", d, got, got_v, exp_v);
               else n_pass++;
            end
            got++;
         end
         if (in_valid_s[d] && in_ready_s[d]) begin
            model_add(DW[d], av, bv, ci, su, er, ec, eo, ez);
            q.push_back({eo, ec, ez, er});
            sent++;
         end
         stalled = out_valid_s[d] && !out_ready_s[d];
         hold_v  = got_v;
         step();
         cyc++;
      end
      n_checks++;
      if (got != 8 || q.size() != 0)
         $display("FAIL bp_count d=%0d got results=%0d pending=%0d exp results=8 pending=0", d, got, q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int seen [ND];
      flush();
      out_ready_s = '0;
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < ND; d++)
            drive(d, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
         step();
      end
      for (int d = 0; d < ND; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      for (int d = 0; d < ND; d++) begin
         n_checks++;
         if ({out_valid_s[d], in_ready_s[d]} !== 2'b01)
            $display("FAIL rst_mid d=%0d got v=%b rdy=%b exp v=0 rdy=1", d, out_valid_s[d], in_ready_s[d]);
         else n_pass++;
         seen[d] = 0;
      end
      rst_n = 1'b1;
      out_ready_s = '1;
      for (int c = 0; c < 12; c++) begin
         step();
         for (int d = 0; d < ND; d++) if (out_valid_s[d]) seen[d]++;
      end
      for (int d = 0; d < ND; d++) begin
         n_checks++;
         if (seen[d] != 0)
            $display("FAIL rst_mid_stale d=%0d got results=%0d exp=0", d, seen[d]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      for (int d = 0; d < ND; d++) test_back_to_back(d);
      for (int d = 0; d < ND; d++) test_backpressure(d);
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
